gray_frame_ctrl: RTL

Raster sequencer placed directly in front of the RGB-to-grayscale conversion stage in the Sobel pipeline. It accepts one RGB pixel per handshake and passes it to the conversion stage unmodified. It counts columns and rows for a programmed frame size and attaches start-of-frame, end-of-line and end-of-frame sideband to each beat. Downstream line buffers and the Sobel window use this sideband for framing. It also gates the stream so that only one frame is in flight per `start_i`.

---
 rtl/gray_frame_ctrl_if.sv | 48 ++++
 rtl/gray_frame_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_ctrl_if.sv
// Stream and control bundle for gray_frame_ctrl: frame start/size, the upstream
// RGB pixel stream and the framed output stream toward the grayscale stage.
interface gray_frame_ctrl_if #(
    parameter int WIDTH_P    = 8,
    parameter int MAX_COLS_P = 640,
    parameter int MAX_ROWS_P = 480
);
    localparam int CW = $clog2(MAX_COLS_P + 1);
    localparam int RW = $clog2(MAX_ROWS_P + 1);
    localparam int XW = $clog2(MAX_COLS_P);
    localparam int YW = $clog2(MAX_ROWS_P);

    // Both pixel streams use valid/ready: a beat moves on a rising edge where
    // valid and ready are both high; once valid is up, the beat holds until ready.
    logic               start_i;
    logic [CW-1:0]      cols_i;
    logic [RW-1:0]      rows_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] red_i;
    logic [WIDTH_P-1:0] green_i;
    logic [WIDTH_P-1:0] blue_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] red_o;
    logic [WIDTH_P-1:0] green_o;
    logic [WIDTH_P-1:0] blue_o;
    logic               sof_o;
    logic               eol_o;
    logic               eof_o;
    logic [XW-1:0]      col_o;
    logic [YW-1:0]      row_o;

    modport slave (
        input  start_i, cols_i, rows_i, valid_i, red_i, green_i, blue_i, ready_i,
        output busy_o, done_o, err_o, ready_o, valid_o, red_o, green_o, blue_o,
               sof_o, eol_o, eof_o, col_o, row_o
    );

    modport master (
        output start_i, cols_i, rows_i, valid_i, red_i, green_i, blue_i, ready_i,
        input  busy_o, done_o, err_o, ready_o, valid_o, red_o, green_o, blue_o,
               sof_o, eol_o, eof_o, col_o, row_o
    );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Raster sequencer ahead of RGB-to-gray: counts col/row, tags sof/eol/eof, one frame per start.
// Define GRAY_FRAME_CTRL_OUTREG_EN for a registered output stage; default is pass-through.
module gray_frame_ctrl #(
    parameter int WIDTH_P    = 8,
    parameter int MAX_COLS_P = 640,
    parameter int MAX_ROWS_P = 480
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    gray_frame_ctrl_if.slave      bus,
    output logic [1:0]            dbg_state_o
);
    localparam int CW = $clog2(MAX_COLS_P + 1);
    localparam int RW = $clog2(MAX_ROWS_P + 1);
    localparam int XW = $clog2(MAX_COLS_P);
    localparam int YW = $clog2(MAX_ROWS_P);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic          eof_taken_q, eof_taken_d;
    logic          err_q, err_d;

    logic size_ok;
    logic running;
    logic in_acc;
    logic out_hs;
    logic out_eof;
    logic is_sof;
    logic is_eol;
    logic is_eof;

    assign size_ok = (bus.cols_i != '0) && (bus.cols_i <= CW'(MAX_COLS_P)) &&
                     (bus.rows_i != '0) && (bus.rows_i <= RW'(MAX_ROWS_P));

    // Once the eof beat is in, input stays closed until the frame drains.
    assign running = (state_q == ST_RUN) && !eof_taken_q;

    assign is_sof = (col_q == '0) && (row_q == '0);
    assign is_eol = (CW'(col_q) == (cols_q - CW'(1)));
    assign is_eof = is_eol && (RW'(row_q) == (rows_q - RW'(1)));

`ifdef GRAY_FRAME_CTRL_OUTREG_EN
    logic                   ov_q, ov_d;
    logic [3*WIDTH_P-1:0]   pix_q, pix_d;
    logic [2:0]             sb_q, sb_d;
    logic [XW-1:0]          ocol_q, ocol_d;
    logic [YW-1:0]          orow_q, orow_d;

    assign bus.ready_o = running && (!ov_q || bus.ready_i);
    assign in_acc      = bus.valid_i && bus.ready_o;
    assign out_hs      = ov_q && bus.ready_i;
    assign out_eof     = sb_q[0];

    always_comb begin
        ov_d   = ov_q;
        pix_d  = pix_q;
        sb_d   = sb_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (in_acc) begin
            ov_d   = 1'b1;
            pix_d  = {bus.red_i, bus.green_i, bus.blue_i};
            sb_d   = {is_sof, is_eol, is_eof};
            ocol_d = col_q;
            orow_d = row_q;
        end else if (bus.ready_i) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ov_q   <= 1'b0;
            pix_q  <= '0;
            sb_q   <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            ov_q   <= ov_d;
            pix_q  <= pix_d;
            sb_q   <= sb_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    assign bus.valid_o = ov_q;
    assign bus.red_o   = pix_q[3*WIDTH_P-1:2*WIDTH_P];
    assign bus.green_o = pix_q[2*WIDTH_P-1:WIDTH_P];
    assign bus.blue_o  = pix_q[WIDTH_P-1:0];
    assign bus.sof_o   = sb_q[2];
    assign bus.eol_o   = sb_q[1];
    assign bus.eof_o   = sb_q[0];
    assign bus.col_o   = ocol_q;
    assign bus.row_o   = orow_q;
`else
    assign bus.valid_o = bus.valid_i && running;
    assign bus.ready_o = bus.ready_i && running;
    assign in_acc      = bus.valid_i && bus.ready_o;
    assign out_hs      = in_acc;
    assign out_eof     = is_eof;

    // Data is forwarded untouched; gating only keeps idle outputs at zero.
    assign bus.red_o   = bus.valid_o ? bus.red_i   : '0;
    assign bus.green_o = bus.valid_o ? bus.green_i : '0;
    assign bus.blue_o  = bus.valid_o ? bus.blue_i  : '0;
    assign bus.sof_o   = bus.valid_o && is_sof;
    assign bus.eol_o   = bus.valid_o && is_eol;
    assign bus.eof_o   = bus.valid_o && is_eof;
    assign bus.col_o   = col_q;
    assign bus.row_o   = row_q;
`endif

    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        col_d       = col_q;
        row_d       = row_q;
        eof_taken_d = eof_taken_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (size_ok) begin
                        cols_d      = bus.cols_i;
                        rows_d      = bus.rows_i;
                        col_d       = '0;
                        row_d       = '0;
                        eof_taken_d = 1'b0;
                        state_d     = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (in_acc) begin
                    if (is_eol) begin
                        col_d = '0;
                        row_d = is_eof ? '0 : row_q + YW'(1);
                        if (is_eof) begin
                            eof_taken_d = 1'b1;
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
                if (out_hs && out_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                eof_taken_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            eof_taken_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            col_q       <= col_d;
            row_q       <= row_d;
            eof_taken_q <= eof_taken_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.done_o  = (state_q == ST_DONE);
    assign bus.err_o   = err_q;
    assign dbg_state_o = state_q;
endmodule
